// File: rtl/alu_pkg.sv
// Shared definitions for the negedge ALU and its upstream command/issue stage.
package alu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        OR  = 3'd3,
        AND = 3'd4,
        XOR = 3'd5,
        SLL = 3'd6,
        SRL = 3'd7
    } opcode_t;

    typedef struct packed {
        logic              chain;
        opcode_t           op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small command FIFO with registered pointers and a one-extra-bit occupancy count.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = alu_cmd_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Storage carries no reset; occupancy is governed solely by the pointers/count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command stage for the negedge ALU: queues commands, issues one at a time,
// captures the ALU result one posedge later and returns it on a response port.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic [2:0]       rsp_op,
    output logic             busy
);

    // Handshakes: a transfer happens on a posedge where valid && ready; once
    // raised, valid and its payload hold until that edge.

    issue_state_t     state_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, last_q;
    opcode_t          alu_op_q;
    logic             rsp_valid_q, rsp_zero_q;
    logic [WIDTH-1:0] rsp_data_q;
    opcode_t          rsp_op_q;

    alu_cmd_t         push_cmd;
    alu_cmd_t         head;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [WIDTH-1:0] issue_a_d;

    assign push_cmd = '{chain: cmd_chain, op: opcode_t'(cmd_op), a: cmd_a, b: cmd_b};

    alu_cmd_fifo #(.DEPTH(DEPTH), .T(alu_cmd_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata (push_cmd),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pop from IDLE, or back-to-back in the same edge as a response handshake.
    assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || (state_q == RESP && rsp_ready));
    assign issue_a_d = head.chain ? last_q : head.a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ADD;
            last_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_op_q    <= ADD;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        alu_a_q  <= issue_a_d;
                        alu_b_q  <= head.b;
                        alu_op_q <= head.op;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_out;
                    rsp_zero_q  <= alu_zero;
                    rsp_op_q    <= alu_op_q;
                    last_q      <= alu_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (fifo_pop) begin
                            alu_a_q  <= issue_a_d;
                            alu_b_q  <= head.b;
                            alu_op_q <= head.op;
                            state_q  <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = !fifo_full;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_op     = rsp_op_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule
